// File: rtl/sevenseg_display_arbiter_if.sv
// Bundles the requester and display-pin signals of sevenseg_display_arbiter.
//  master : requester/board side (drives requests, values and blank; sees grants and pins)
//  slave  : arbiter side
interface sevenseg_display_arbiter_if;
  logic        req_score;
  logic [15:0] score_val;
  logic        req_key;
  logic [7:0]  key_val;
  logic        blank;
  logic        gnt_score;
  logic        gnt_key;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output req_score, score_val, req_key, key_val, blank,
    input  gnt_score, gnt_key, an, seg
  );

  modport slave (
    input  req_score, score_val, req_key, key_val, blank,
    output gnt_score, gnt_key, an, seg
  );
endinterface

// File: rtl/sevenseg_display_arbiter.sv
// Shares a 4-digit seven-segment display between a score source (4 nibbles)
// and a keycode source (2 nibbles). Ownership changes only at frame ends and
// after a minimum hold, so digits never tear. Also drives the anode scan and
// the active-low segment font.
//  CLK, RST_N : clock, asynchronous active-low reset
//  bus.req_score/score_val, bus.req_key/key_val : requesters
//  bus.blank  : force display off and drop ownership
//  bus.gnt_score/gnt_key : current owner (registered)
//  bus.an/seg : anode enables and segments {g,f,e,d,c,b,a}, active low
module sevenseg_display_arbiter #(
  parameter int unsigned DIGIT_TIME  = 200000,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  sevenseg_display_arbiter_if.slave    bus
);

  localparam int unsigned TICK_W  = (DIGIT_TIME > 1) ? $clog2(DIGIT_TIME) : 1;
  localparam int unsigned FRAME_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(DIGIT_TIME - 1);
  localparam logic [FRAME_W-1:0] HOLD      = FRAME_W'(HOLD_FRAMES);

  typedef enum logic [1:0] {ST_IDLE, ST_SCORE, ST_KEY} state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [1:0]           digit_q, digit_d;
  logic [FRAME_W-1:0]   frames_q, frames_d, frames_inc;
  logic [15:0]          value_q, value_d, own_val, other_val;
  logic                 show_q, show_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 gnt_score_q, gnt_key_q;
  logic                 terminal, frame_end, own_req, other_req, lit;
  logic [3:0]           nibble;

  // Hex font, active low {g,f,e,d,c,b,a}
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'b1000000;
      4'h1: font = 7'b1111001;
      4'h2: font = 7'b0100100;
      4'h3: font = 7'b0110000;
      4'h4: font = 7'b0011001;
      4'h5: font = 7'b0010010;
      4'h6: font = 7'b0000010;
      4'h7: font = 7'b1111000;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0010000;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b0000011;
      4'hC: font = 7'b1000110;
      4'hD: font = 7'b0100001;
      4'hE: font = 7'b0000110;
      default: font = 7'b0001110;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      digit_q     <= '0;
      frames_q    <= '0;
      value_q     <= '0;
      show_q      <= 1'b0;
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
      gnt_score_q <= 1'b0;
      gnt_key_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      digit_q     <= digit_d;
      frames_q    <= frames_d;
      value_q     <= value_d;
      show_q      <= show_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      gnt_score_q <= (state_d == ST_SCORE);
      gnt_key_q   <= (state_d == ST_KEY);
    end
  end

  // Scan, arbitration and display decode
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q + TICK_W'(1);
    digit_d  = digit_q;
    frames_d = frames_q;
    value_d  = value_q;
    an_d     = 4'hF;
    seg_d    = 7'h7F;

    terminal   = (tick_q == TICK_LAST);
    frame_end  = terminal && (digit_q == 2'd3);
    frames_inc = (frames_q >= HOLD) ? HOLD : frames_q + FRAME_W'(1);
    own_req    = (state_q == ST_KEY) ? bus.req_key : bus.req_score;
    other_req  = (state_q == ST_KEY) ? bus.req_score : bus.req_key;
    own_val    = (state_q == ST_KEY) ? {8'h00, bus.key_val} : bus.score_val;
    other_val  = (state_q == ST_KEY) ? bus.score_val : {8'h00, bus.key_val};

    if (terminal) begin
      tick_d  = '0;
      digit_d = digit_q + 2'd1;
    end

    if (bus.blank) begin
      state_d  = ST_IDLE;
      frames_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          frames_d = '0;
          if (bus.req_score) begin
            state_d = ST_SCORE;
            value_d = bus.score_val;
          end else if (bus.req_key) begin
            state_d = ST_KEY;
            value_d = {8'h00, bus.key_val};
          end
        end
        ST_SCORE, ST_KEY: begin
          // frames_inc counts the frame ending now; the hold is served once
          // HOLD_FRAMES frame ends have been seen.
          if (frame_end) begin
            frames_d = frames_inc;
            if (frames_inc == HOLD && other_req) begin
              state_d  = (state_q == ST_SCORE) ? ST_KEY : ST_SCORE;
              frames_d = '0;
              value_d  = other_val;
            end else if (frames_inc == HOLD && !own_req) begin
              state_d  = ST_IDLE;
              frames_d = '0;
            end else if (own_req) begin
              value_d  = own_val;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A fresh owner lights up only from the next digit boundary
    show_d = (state_q == ST_IDLE) ? 1'b0 : (terminal ? 1'b1 : show_q);

    nibble = 4'(value_q >> {digit_q, 2'b00});
    lit    = (state_q != ST_IDLE) && show_q && !((state_q == ST_KEY) && digit_q[1]);
    if (lit) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = font(nibble);
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.gnt_score = gnt_score_q;
  assign bus.gnt_key   = gnt_key_q;

endmodule

// File: tb/tb_sevenseg_display_arbiter.sv
// Self-checking bench for sevenseg_display_arbiter (DIGIT_TIME=4, HOLD_FRAMES=2).
// A cycle-level reference model derives scan position from the edge count and
// tracks the owner, its hold count and the latched value.
module tb_sevenseg_display_arbiter;
  localparam int unsigned DT    = 4;
  localparam int unsigned HF    = 2;
  localparam int unsigned FRAME = 4 * DT;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  sevenseg_display_arbiter_if bus ();

  sevenseg_display_arbiter #(.DIGIT_TIME(DT), .HOLD_FRAMES(HF)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n;        // edges since reset release
  int          own;      // 0 none, 1 score, 2 key
  int          m_frames;
  logic [15:0] m_lat;
  bit          m_show;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic [6:0]  font_tbl [16];

  task automatic model_reset();
    n = 0; own = 0; m_frames = 0; m_lat = '0; m_show = 0;
    m_an = 4'hF; m_seg = 7'h7F;
  endtask

  task automatic model_edge();
    int digit, done;
    bit term, fend, rs, rk, bl, lit, mine, other;
    logic [15:0] sv;
    logic [7:0]  kv;
    logic [3:0]  onehot, nib;
    digit = (n / DT) % 4;
    term  = (n % DT) == DT - 1;
    fend  = (n % FRAME) == FRAME - 1;
    rs = bus.req_score; rk = bus.req_key; bl = bus.blank;
    sv = bus.score_val; kv = bus.key_val;
    lit    = own != 0 && m_show && !(own == 2 && digit >= 2);
    onehot = 4'(1 << digit);
    nib    = 4'(m_lat >> (4 * digit));
    m_an   = lit ? ~onehot : 4'hF;
    m_seg  = lit ? font_tbl[nib] : 7'h7F;
    if (own == 0) m_show = 0;
    else if (term) m_show = 1;
    if (bl) begin
      own = 0; m_frames = 0;
    end else if (own == 0) begin
      m_frames = 0;
      if (rs) begin own = 1; m_lat = sv; end
      else if (rk) begin own = 2; m_lat = {8'h00, kv}; end
    end else if (fend) begin
      done  = (m_frames + 1 > HF) ? HF : m_frames + 1;
      mine  = (own == 1) ? rs : rk;
      other = (own == 1) ? rk : rs;
      if (done == HF && other) begin
        own = 3 - own; m_frames = 0;
        m_lat = (own == 1) ? sv : {8'h00, kv};
      end else if (done == HF && !mine) begin
        own = 0; m_frames = 0;
      end else begin
        m_frames = done;
        if (mine) m_lat = (own == 1) ? sv : {8'h00, kv};
      end
    end
    n++;
  endtask

  // One clock edge; model follows, outputs are sampled 1 time unit later
  task automatic tick_clk();
    @(posedge CLK);
    if (RST_N) model_edge(); else model_reset();
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_score = 0; bus.req_key = 0; bus.blank = 0;
    bus.score_val = '0; bus.key_val = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_N = 0;
    repeat (3) tick_clk();
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.gnt_score !== 1'b0 || bus.gnt_key !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: an=%b seg=%b gs=%b gk=%b, need 1111/1111111/0/0", bus.an, bus.seg, bus.gnt_score, bus.gnt_key);
    end
    checks++;
    RST_N = 1;
    for (int i = 0; i < 40; i++) begin
      tick_clk();
      if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.gnt_score !== 1'b0 || bus.gnt_key !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: an=%b seg=%b gs=%b gk=%b, need 1111/1111111/0/0", i, bus.an, bus.seg, bus.gnt_score, bus.gnt_key);
      end
      checks++;
    end
  endtask

  task automatic test_score_frame();
    logic [3:0] ea [4];
    logic [6:0] es [4];
    int k;
    ea[0] = 4'b1110; ea[1] = 4'b1101; ea[2] = 4'b1011; ea[3] = 4'b0111;
    es[0] = 7'b0001110; es[1] = 7'b0001000; es[2] = 7'b0100100; es[3] = 7'b1111001;
    bus.score_val = 16'h12AF; bus.req_score = 1;
    tick_clk();
    if (bus.gnt_score !== 1'b1 || bus.gnt_key !== 1'b0) begin
      errors++;
      $display("FAIL score_grant: gs=%b gk=%b, need 1/0", bus.gnt_score, bus.gnt_key);
    end
    checks++;
    k = 0;
    while (bus.an !== 4'b1110 && k < FRAME + 4) begin
      if (bus.an !== m_an || bus.seg !== m_seg) begin
        errors++;
        $display("FAIL score_startup: an=%b seg=%b, need %b/%b", bus.an, bus.seg, m_an, m_seg);
      end
      checks++;
      tick_clk(); k++;
    end
    if (k >= FRAME + 4) begin
      errors++;
      $display("FAIL score_wait_digit0: an=%b never reached 1110 in %0d cycles", bus.an, k);
    end
    checks++;
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++) begin
        if (bus.an !== ea[d] || bus.seg !== es[d]) begin
          errors++;
          $display("FAIL score_frame d%0d c%0d: an=%b seg=%b, need %b/%b", d, c, bus.an, bus.seg, ea[d], es[d]);
        end
        checks++;
        tick_clk();
      end
    bus.req_score = 0;
    k = 0;
    while (bus.gnt_score !== 1'b0 && k < 4 * FRAME) begin tick_clk(); k++; end
    if (k >= 4 * FRAME) begin
      errors++;
      $display("FAIL score_release: gs=%b still set after %0d cycles, need 0", bus.gnt_score, k);
    end
    checks++;
    tick_clk();
  endtask

  task automatic test_key();
    int k;
    bus.key_val = 8'h3C; bus.req_key = 1;
    tick_clk();
    if (bus.gnt_key !== 1'b1 || bus.gnt_score !== 1'b0) begin
      errors++;
      $display("FAIL key_grant: gk=%b gs=%b, need 1/0", bus.gnt_key, bus.gnt_score);
    end
    checks++;
    k = 0;
    while (bus.an !== 4'b1110 && k < FRAME + 4) begin tick_clk(); k++; end
    if (k >= FRAME + 4) begin
      errors++;
      $display("FAIL key_wait_digit0: an=%b never reached 1110", bus.an);
    end
    checks++;
    for (int c = 0; c < FRAME; c++) begin
      logic [3:0] xa;
      logic [6:0] xs;
      xa = (c < 4) ? 4'b1110 : (c < 8) ? 4'b1101 : 4'b1111;
      xs = (c < 4) ? 7'b1000110 : (c < 8) ? 7'b0110000 : 7'b1111111;
      if (bus.an !== xa || bus.seg !== xs) begin
        errors++;
        $display("FAIL key_frame c%0d: an=%b seg=%b, need %b/%b", c, bus.an, bus.seg, xa, xs);
      end
      checks++;
      tick_clk();
    end
    bus.req_key = 0;
    k = 0;
    while (bus.gnt_key !== 1'b0 && k < 4 * FRAME) begin tick_clk(); k++; end
    if (k >= 4 * FRAME) begin
      errors++;
      $display("FAIL key_release: gk=%b still set, need 0", bus.gnt_key);
    end
    checks++;
    tick_clk();
  endtask

  task automatic test_alternate();
    int t1, t2, t3, k;
    bit ps, pk;
    t1 = -1; t2 = -1; t3 = -1;
    bus.score_val = 16'($urandom); bus.key_val = 8'($urandom);
    bus.req_score = 1; bus.req_key = 1;
    tick_clk();
    if (bus.gnt_score !== 1'b1 || bus.gnt_key !== 1'b0) begin
      errors++;
      $display("FAIL both_score_first: gs=%b gk=%b, need 1/0", bus.gnt_score, bus.gnt_key);
    end
    checks++;
    ps = bus.gnt_score; pk = bus.gnt_key;
    for (k = 1; k < 12 * FRAME && t3 < 0; k++) begin
      tick_clk();
      if (bus.an !== m_an || bus.seg !== m_seg || bus.gnt_score !== 1'(own == 1) || bus.gnt_key !== 1'(own == 2)) begin
        errors++;
        $display("FAIL alt_model k%0d: an=%b seg=%b gs=%b gk=%b, need %b/%b/%0b/%0b", k, bus.an, bus.seg,
                 bus.gnt_score, bus.gnt_key, m_an, m_seg, own == 1, own == 2);
      end
      checks++;
      if ((bus.gnt_key && !pk) || (bus.gnt_score && !ps)) begin
        if ((n % FRAME) != 0) begin
          errors++;
          $display("FAIL alt_boundary: switch at scan position %0d, need 0", n % FRAME);
        end
        checks++;
        if (t1 < 0) t1 = k; else if (t2 < 0) t2 = k; else t3 = k;
      end
      ps = bus.gnt_score; pk = bus.gnt_key;
    end
    if (t3 < 0 || (t2 - t1) != 2 * FRAME || (t3 - t2) != 2 * FRAME) begin
      errors++;
      $display("FAIL alt_period: switches at %0d,%0d,%0d, need spacing %0d", t1, t2, t3, 2 * FRAME);
    end
    checks++;
    bus.req_score = 0; bus.req_key = 0;
    k = 0;
    while ((bus.gnt_score || bus.gnt_key) && k < 4 * FRAME) begin tick_clk(); k++; end
    if (k >= 4 * FRAME) begin
      errors++;
      $display("FAIL alt_release: gs=%b gk=%b, need 0/0", bus.gnt_score, bus.gnt_key);
    end
    checks++;
    tick_clk();
  endtask

  task automatic test_freeze();
    int k;
    bus.score_val = 16'h1111; bus.req_score = 1;
    tick_clk();
    k = 0;
    while (bus.an !== 4'b1110 && k < FRAME + 4) begin tick_clk(); k++; end
    if (k >= FRAME + 4) begin
      errors++;
      $display("FAIL freeze_wait: an=%b never reached 1110", bus.an);
    end
    checks++;
    tick_clk(); tick_clk();
    bus.score_val = 16'h2222;
    // Rest of this frame still shows the old value, next frame the new one
    for (int c = 2; c < 2 * FRAME; c++) begin
      logic [6:0] xs;
      xs = (c < FRAME) ? 7'b1111001 : 7'b0100100;
      if (bus.seg !== xs || bus.seg !== m_seg || bus.an !== m_an) begin
        errors++;
        $display("FAIL freeze_update c%0d: seg=%b an=%b, need %b/%b", c, bus.seg, bus.an, xs, m_an);
      end
      checks++;
      tick_clk();
    end
    // Drop mid-frame: value frozen at 2 until the hold ends
    tick_clk(); tick_clk();
    bus.req_score = 0; bus.score_val = 16'h3333;
    k = 0;
    while (bus.gnt_score === 1'b1 && k < 4 * FRAME) begin
      if (bus.an !== m_an || bus.seg !== m_seg || (bus.an !== 4'hF && bus.seg !== 7'b0100100)) begin
        errors++;
        $display("FAIL freeze_hold k%0d: an=%b seg=%b, need %b/%b", k, bus.an, bus.seg, m_an, m_seg);
      end
      checks++;
      tick_clk(); k++;
    end
    if (k >= 4 * FRAME || own != 0) begin
      errors++;
      $display("FAIL freeze_idle: gs=%b after %0d cycles, need 0 with model idle", bus.gnt_score, k);
    end
    checks++;
    tick_clk();
  endtask

  task automatic test_blank();
    int k;
    bus.score_val = 16'h5A5A; bus.req_score = 1;
    tick_clk();
    k = 0;
    while (bus.an === 4'hF && k < FRAME + 4) begin tick_clk(); k++; end
    tick_clk();
    bus.blank = 1;
    tick_clk();
    if (bus.gnt_score !== 1'b0) begin
      errors++;
      $display("FAIL blank_gnt: gs=%b, need 0", bus.gnt_score);
    end
    checks++;
    tick_clk();
    if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
      errors++;
      $display("FAIL blank_dark: an=%b seg=%b, need 1111/1111111", bus.an, bus.seg);
    end
    checks++;
    repeat (3) tick_clk();
    if (bus.gnt_score !== 1'b0 || bus.an !== 4'hF) begin
      errors++;
      $display("FAIL blank_held: gs=%b an=%b, need 0/1111", bus.gnt_score, bus.an);
    end
    checks++;
    bus.blank = 0; bus.req_score = 0; bus.req_key = 1; bus.key_val = 8'h7E;
    tick_clk();
    if (bus.gnt_key !== 1'b1 || bus.gnt_score !== 1'b0) begin
      errors++;
      $display("FAIL blank_release_key: gk=%b gs=%b, need 1/0", bus.gnt_key, bus.gnt_score);
    end
    checks++;
    repeat (FRAME) tick_clk();
  endtask

  task automatic test_reset_mid();
    bus.req_key = 1;
    repeat (5) tick_clk();
    RST_N = 0;
    #1;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.gnt_score !== 1'b0 || bus.gnt_key !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: an=%b seg=%b gs=%b gk=%b, need 1111/1111111/0/0", bus.an, bus.seg, bus.gnt_score, bus.gnt_key);
    end
    checks++;
    model_reset();
    idle_inputs();
    tick_clk();
    RST_N = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.req_score = ~bus.req_score;
      if ($urandom_range(0, 39) == 0) bus.req_key = ~bus.req_key;
      if ($urandom_range(0, 9) == 0)  bus.score_val = 16'($urandom);
      if ($urandom_range(0, 9) == 0)  bus.key_val = 8'($urandom);
      bus.blank = ($urandom_range(0, 149) == 0);
      tick_clk();
      if (bus.an !== m_an || bus.seg !== m_seg || bus.gnt_score !== 1'(own == 1) || bus.gnt_key !== 1'(own == 2)) begin
        errors++;
        $display("FAIL random i%0d: an=%b seg=%b gs=%b gk=%b, need %b/%b/%0b/%0b", i, bus.an, bus.seg,
                 bus.gnt_score, bus.gnt_key, m_an, m_seg, own == 1, own == 2);
      end
      checks++;
    end
  endtask

  initial begin
    font_tbl[0]  = 7'b1000000; font_tbl[1]  = 7'b1111001; font_tbl[2]  = 7'b0100100; font_tbl[3]  = 7'b0110000;
    font_tbl[4]  = 7'b0011001; font_tbl[5]  = 7'b0010010; font_tbl[6]  = 7'b0000010; font_tbl[7]  = 7'b1111000;
    font_tbl[8]  = 7'b0000000; font_tbl[9]  = 7'b0010000; font_tbl[10] = 7'b0001000; font_tbl[11] = 7'b0000011;
    font_tbl[12] = 7'b1000110; font_tbl[13] = 7'b0100001; font_tbl[14] = 7'b0000110; font_tbl[15] = 7'b0001110;
    model_reset();
    test_reset();
    test_score_frame();
    test_key();
    test_alternate();
    test_freeze();
    test_blank();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
